comparator: RTL and testbench
=============================

Name: comparator

Overview:
- Registered magnitude/equality comparator for the stage-2 datapath; feeds the branch-resolution unit.
- Compares two WIDTH-bit register-file operands, rs1d and rs2d.
- Produces equal and less-than flags, signed or unsigned as selected by s.
- Flags are registered: one clock of latency from input sample to output.

Parameters:
WIDTH, 32, operand width in bits (legal values >= 2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
rs1d  input  WIDTH  operand A (left-hand side)
rs2d  input  WIDTH  operand B (right-hand side)
s  input  1  compare mode: 1 = signed two's complement, 0 = unsigned
eq  output  1  registered flag, 1 when rs1d == rs2d
lt  output  1  registered flag, 1 when rs1d < rs2d under mode s

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Reset: at a posedge with rst=1, eq<=0 and lt<=0. Reset has priority over the new comparison. Inputs present at that edge are discarded.
- Latency 1: at each posedge with rst=0, the block samples rs1d, rs2d and s and registers the result. eq and lt reflect that sample until the next posedge.
- No handshake and no stall. Every cycle is a new comparison; back-to-back changes are fully pipelined.
- eq:
  - Bitwise equality of all WIDTH bits.
  - Independent of s.
- lt, unsigned (s=0): rs1d < rs2d as unsigned integers.
- lt, signed (s=1): rs1d < rs2d as two's-complement integers.
  - If the MSBs differ, lt = rs1d[WIDTH-1].
  - Otherwise lt = unsigned compare of the low WIDTH-1 bits.
- Invariant: eq and lt are never both 1.
- Boundaries:
  - 0x80000000 vs 0x7FFFFFFF gives lt=1 signed, lt=0 unsigned.
  - 0xFFFFFFFF vs 0x00000000 gives lt=1 signed, lt=0 unsigned.
  - Equal operands give eq=1, lt=0 in both modes.
- Implementation constraints:
  - Purely synchronous outputs; no combinational path from inputs to eq or lt.
  - No latches.
  - X on inputs is not required to be handled.
- Structure: the compare is built as a hierarchical group tree.
  - 4-bit leaf groups each produce local eq and lt.
  - Groups merge MSB-first: lt = lt_hi | (eq_hi & lt_lo), eq = eq_hi & eq_lo.
  - The sign adjustment is applied at the top level only.
  - When WIDTH is not a multiple of 4, it is padded with zeros at the MSB side of the unsigned tree.

Optional Feature:
- Macro: COMPARATOR_FLAGS_EN.
- Defined:
  - Adds two registered outputs, gt (rs1d > rs2d under s) and ge (eq | gt).
  - Both have the same latency and reset value (0) as eq and lt.
  - Invariant: exactly one of lt, eq, gt is 1 whenever not in reset.
- Undefined: gt and ge ports do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with rs1d=rs2d=0x5 -> eq=0, lt=0. Release rst -> after the next posedge, eq=1, lt=0.
- Equality: rs1d=rs2d=0xDEADBEEF with s=0, then with s=1 -> eq=1, lt=0 in both cycles.
- Sign boundary: rs1d=0xFFFFFFFF, rs2d=0x00000001.
  - s=1 -> lt=1, eq=0.
  - s=0 -> lt=0, eq=0.
- MSB boundary: rs1d=0x80000000, rs2d=0x7FFFFFFF.
  - s=1 -> lt=1.
  - s=0 -> lt=0.
  - Swapped operands -> inverted lt, eq=0.
- Latency: apply 0x1 vs 0x2, then 0x2 vs 0x1 on consecutive cycles -> lt=1 one cycle after the first, lt=0 one cycle after the second.
- Random: 100 vectors applied at negedge, checked one PROP_DELAY after posedge against a reference model, both modes. With COMPARATOR_FLAGS_EN also check gt/ge consistency.

Source files
------------

// File: rtl/comparator.sv
// Registered equal / less-than comparator with selectable signed or unsigned mode.
// Optional gt/ge outputs are enabled by defining COMPARATOR_FLAGS_EN.
`timescale 1ns/1ps

module comparator #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rs1d,
  input  logic [WIDTH-1:0] rs2d,
  input  logic             s,
  output logic             eq,
  output logic             lt
`ifdef COMPARATOR_FLAGS_EN
  ,
  output logic             gt,
  output logic             ge
`endif
);

  localparam int NG = (WIDTH + 3) / 4;
  localparam int PW = NG * 4;
  localparam int LV = $clog2(NG);

  logic [PW-1:0]   a_pad, b_pad;
  logic [NG-1:0]   leaf_eq, leaf_lt;
  logic [2*NG-1:0] t_eq, t_lt;
  logic            msb_diff;
  logic            eq_d, lt_d, eq_q, lt_q;
  int              n;

  // Operands are zero-padded at the MSB end so every leaf group is a full 4 bits.
  always_comb begin
    // NOTE: every variable gets a value before any branch, so no path leaves it holding state.
    a_pad = '0;
    b_pad = '0;
    a_pad[WIDTH-1:0] = rs1d;
    b_pad[WIDTH-1:0] = rs2d;
    for (int g = 0; g < NG; g++) begin
      leaf_eq[g] = (a_pad[4*g +: 4] == b_pad[4*g +: 4]);
      leaf_lt[g] = (a_pad[4*g +: 4] <  b_pad[4*g +: 4]);
    end
  end

  // Pairwise MSB-first merge, in place: slot i takes groups 2i+1 (high) and 2i (low),
  // both of which are read before slot i is overwritten.
  always_comb begin
    t_eq = '0;
    t_lt = '0;
    t_eq[NG-1:0] = leaf_eq;
    t_lt[NG-1:0] = leaf_lt;
    n = NG;
    for (int lvl = 0; lvl < LV; lvl++) begin
      for (int i = 0; i < NG; i++) begin
        if (2*i + 1 < n) begin
          t_lt[i] = t_lt[2*i+1] | (t_eq[2*i+1] & t_lt[2*i]);
          t_eq[i] = t_eq[2*i+1] & t_eq[2*i];
        end else if (2*i < n) begin
          t_lt[i] = t_lt[2*i];
          t_eq[i] = t_eq[2*i];
        end
      end
      n = (n + 1) / 2;
    end
  end

  // Signed mode only differs from the unsigned tree when the sign bits disagree.
  always_comb begin
    msb_diff = rs1d[WIDTH-1] ^ rs2d[WIDTH-1];
    eq_d     = t_eq[0];
    lt_d     = (s && msb_diff) ? rs1d[WIDTH-1] : t_lt[0];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      eq_q <= 1'b0;
      lt_q <= 1'b0;
    end else begin
      eq_q <= eq_d;
      lt_q <= lt_d;
    end
  end

  assign eq = eq_q;
  assign lt = lt_q;

`ifdef COMPARATOR_FLAGS_EN
  logic gt_d, ge_d, gt_q, ge_q;

  always_comb begin
    gt_d = ~lt_d & ~eq_d;
    ge_d = ~lt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gt_q <= 1'b0;
      ge_q <= 1'b0;
    end else begin
      gt_q <= gt_d;
      ge_q <= ge_d;
    end
  end

  assign gt = gt_q;
  assign ge = ge_q;
`endif

endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench for comparator: driver pushes expected flags per cycle,
// monitor pops and compares one clock later. Define COMPARATOR_FLAGS_EN to cover gt/ge.
`timescale 1ns/1ps

module tb_comparator;

  localparam int W = 32;

  typedef struct {
    logic [3:0] flags;  // {ge, gt, lt, eq}
    string      name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] rs1d = '0;
  logic [W-1:0] rs2d = '0;
  logic         s = 1'b0;
  logic         eq, lt;
`ifdef COMPARATOR_FLAGS_EN
  logic         gt, ge;
`endif

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  comparator #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .rs1d (rs1d),
    .rs2d (rs2d),
    .s    (s),
    .eq   (eq),
    .lt   (lt)
`ifdef COMPARATOR_FLAGS_EN
    ,
    .gt   (gt),
    .ge   (ge)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: flags {ge,gt,lt,eq} got %b, expected %b", name, got, want);
    end
  endtask

  // Reference model: integer comparison straight from the operand values.
  function automatic logic [3:0] model(input logic r, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic sm);
    logic m_eq, m_lt, m_gt;
    if (r) return 4'b0000;
    m_eq = (a == b);
    if (sm) m_lt = ($signed(a) < $signed(b));
    else    m_lt = (a < b);
    m_gt = !m_eq && !m_lt;
    return {m_gt | m_eq, m_gt, m_lt, m_eq};
  endfunction

  task automatic apply(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sm, input string nm);
    exp_t e;
    @(negedge clk);
    rst  = r;
    rs1d = a;
    rs2d = b;
    s    = sm;
    e.flags = model(r, a, b, sm);
    e.name  = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: one expected entry is consumed per posedge, sampled just after the edge.
  initial begin
    exp_t       e;
    logic [3:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
`ifdef COMPARATOR_FLAGS_EN
        got = {ge, gt, lt, eq};
        check(e.name, got, e.flags);
        if (!rst) check({e.name, "_onehot"}, {3'b000, $onehot({lt, eq, gt})}, 4'b0001);
`else
        got = {2'b00, lt, eq};
        check(e.name, got, {2'b00, e.flags[1:0]});
`endif
        check({e.name, "_not_eq_and_lt"}, {3'b000, eq & lt}, 4'b0000);
      end
    end
  end

  initial begin
    logic [W-1:0] a, b;
    logic         sm;

    apply(1'b1, 32'h5, 32'h5, 1'b0, "reset_0");
    apply(1'b1, 32'h5, 32'h5, 1'b0, "reset_1");
    apply(1'b0, 32'h5, 32'h5, 1'b0, "reset_release_eq");

    apply(1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "equal_unsigned");
    apply(1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, "equal_signed");

    apply(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b1, "sign_neg1_vs_1_signed");
    apply(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, "sign_neg1_vs_1_unsigned");
    apply(1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, "neg1_vs_0_signed");
    apply(1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0, "neg1_vs_0_unsigned");

    apply(1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b1, "msb_min_vs_max_signed");
    apply(1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0, "msb_min_vs_max_unsigned");
    apply(1'b0, 32'h7FFFFFFF, 32'h80000000, 1'b1, "msb_swapped_signed");
    apply(1'b0, 32'h7FFFFFFF, 32'h80000000, 1'b0, "msb_swapped_unsigned");

    apply(1'b0, 32'h1, 32'h2, 1'b0, "latency_1_vs_2");
    apply(1'b0, 32'h2, 32'h1, 1'b0, "latency_2_vs_1");

    // Reset in mid-stream discards the sample taken at that edge.
    apply(1'b1, 32'h1, 32'h2, 1'b0, "midstream_reset");

    for (int i = 0; i < 100; i++) begin
      a  = $urandom;
      b  = $urandom;
      sm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = a;
        1: b = a ^ (32'h1 << $urandom_range(0, W-1));
        2: b = {~a[W-1], a[W-2:0]};
        default: ;
      endcase
      apply(1'b0, a, b, sm, $sformatf("random_%0d", i));
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", {1'b0, 3'(sb_q.size() > 0 ? 3'd1 : 3'd0)}, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
